// File: rtl/bin_onehot_pipe_if.sv
// bin_onehot_pipe_if: handshake bundle for bin_onehot_pipe.
//   Input side : in_valid/in_ready with in_mode, in_bin, in_onehot operands.
//   Output side: out_valid/out_ready with out_bin, out_onehot, out_err results.
//   Status     : err_count, saturating count of erroneous results delivered.
// slave modport is the converter; master modport is the producer/consumer.
interface bin_onehot_pipe_if #(
  parameter int BIN_WIDTH    = 4,
  parameter int ONEHOT_WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic [BIN_WIDTH-1:0]    in_bin;
  logic [ONEHOT_WIDTH-1:0] in_onehot;
  logic                    out_valid;
  logic                    out_ready;
  logic [BIN_WIDTH-1:0]    out_bin;
  logic [ONEHOT_WIDTH-1:0] out_onehot;
  logic                    out_err;
  logic [15:0]             err_count;

  modport slave (
    input  in_valid, in_mode, in_bin, in_onehot, out_ready,
    output in_ready, out_valid, out_bin, out_onehot, out_err, err_count
  );

  modport master (
    output in_valid, in_mode, in_bin, in_onehot, out_ready,
    input  in_ready, out_valid, out_bin, out_onehot, out_err, err_count
  );
endinterface

// File: rtl/bin_onehot_pipe.sv
// bin_onehot_pipe: pipelined binary/one-hot/thermometer converter with a
// valid/ready handshake and a 2-entry output store (output register + skid).
//   clk : sole clock, rising edge.
//   rst : synchronous, active-low reset.
//   bus : bin_onehot_pipe_if.slave carrying the in_*/out_* handshakes and
//         the saturating err_count.
// Modes: 00 decode, 01 encode (lowest set bit), 10 thermometer, 11 reserved.
module bin_onehot_pipe #(
  parameter int BIN_WIDTH    = 4,
  parameter int ONEHOT_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  bin_onehot_pipe_if.slave bus
);

  localparam logic [1:0]  MODE_DEC   = 2'b00;
  localparam logic [1:0]  MODE_ENC   = 2'b01;
  localparam logic [1:0]  MODE_THERM = 2'b10;
  localparam logic [15:0] ERR_MAX    = 16'hFFFF;

  logic                    accept_s;
  logic                    deliver_s;
  logic [31:0]             bin_ext_s;
  logic [31:0]             pop_s;
  logic [BIN_WIDTH-1:0]    low_idx_s;
  logic [BIN_WIDTH-1:0]    res_bin_s;
  logic [ONEHOT_WIDTH-1:0] res_onehot_s;
  logic                    res_err_s;

  logic                    out_valid_q, out_valid_d;
  logic [BIN_WIDTH-1:0]    out_bin_q, out_bin_d;
  logic [ONEHOT_WIDTH-1:0] out_onehot_q, out_onehot_d;
  logic                    out_err_q, out_err_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [BIN_WIDTH-1:0]    skid_bin_q, skid_bin_d;
  logic [ONEHOT_WIDTH-1:0] skid_onehot_q, skid_onehot_d;
  logic                    skid_err_q, skid_err_d;
  logic                    in_ready_q, in_ready_d;
  logic [15:0]             err_count_q, err_count_d;

  assign accept_s  = bus.in_valid && in_ready_q;
  assign deliver_s = out_valid_q && bus.out_ready;

  // Combinational conversion of the operands currently on the input side.
  always_comb begin
    bin_ext_s    = 32'(bus.in_bin);
    pop_s        = 32'd0;
    low_idx_s    = '0;
    res_bin_s    = '0;
    res_onehot_s = '0;
    res_err_s    = 1'b0;
    // Scanning downwards leaves the lowest set index in low_idx_s.
    for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
      pop_s     = pop_s + {31'd0, bus.in_onehot[i]};
      low_idx_s = bus.in_onehot[i] ? BIN_WIDTH'(i) : low_idx_s;
    end
    case (bus.in_mode)
      MODE_DEC: begin
        // Out-of-range codes match no bit, so the vector is naturally zero.
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
          res_onehot_s[i] = (bin_ext_s == 32'(i));
        end
        res_bin_s = bus.in_bin;
        res_err_s = (bin_ext_s >= 32'(ONEHOT_WIDTH));
      end
      MODE_ENC: begin
        res_onehot_s = bus.in_onehot;
        res_bin_s    = low_idx_s;
        res_err_s    = (pop_s != 32'd1);
      end
      MODE_THERM: begin
        // Out-of-range codes satisfy every comparison, giving all ones.
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
          res_onehot_s[i] = (32'(i) <= bin_ext_s);
        end
        res_bin_s = bus.in_bin;
        res_err_s = (bin_ext_s >= 32'(ONEHOT_WIDTH));
      end
      default: begin
        res_bin_s    = '0;
        res_onehot_s = '0;
        res_err_s    = 1'b1;
      end
    endcase
  end

  // Next-state of the output register, skid register, ready and error count.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_bin_d     = out_bin_q;
    out_onehot_d  = out_onehot_q;
    out_err_d     = out_err_q;
    skid_valid_d  = skid_valid_q;
    skid_bin_d    = skid_bin_q;
    skid_onehot_d = skid_onehot_q;
    skid_err_d    = skid_err_q;
    if (!out_valid_q || deliver_s) begin
      // Output slot frees up: the older skid entry always goes first.
      // An accept cannot coincide with a full skid because in_ready is low.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_bin_d    = skid_bin_q;
        out_onehot_d = skid_onehot_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_valid_d  = 1'b1;
        out_bin_d    = res_bin_s;
        out_onehot_d = res_onehot_s;
        out_err_d    = res_err_s;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_d  = 1'b1;
        skid_bin_d    = res_bin_s;
        skid_onehot_d = res_onehot_s;
        skid_err_d    = res_err_s;
      end else begin
        skid_valid_d  = skid_valid_q;
      end
    end
    in_ready_d = !skid_valid_d;
    if (deliver_s && out_err_q && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 16'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q   <= 1'b0;
      out_bin_q     <= '0;
      out_onehot_q  <= '0;
      out_err_q     <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_bin_q    <= '0;
      skid_onehot_q <= '0;
      skid_err_q    <= 1'b0;
      in_ready_q    <= 1'b0;
      err_count_q   <= 16'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_bin_q     <= out_bin_d;
      out_onehot_q  <= out_onehot_d;
      out_err_q     <= out_err_d;
      skid_valid_q  <= skid_valid_d;
      skid_bin_q    <= skid_bin_d;
      skid_onehot_q <= skid_onehot_d;
      skid_err_q    <= skid_err_d;
      in_ready_q    <= in_ready_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bin    = out_bin_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.out_err    = out_err_q;
  assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_bin_onehot_pipe.sv
// tb_bin_onehot_pipe: scoreboard bench for bin_onehot_pipe (BIN_WIDTH=4,
// ONEHOT_WIDTH=12). Stimulus pushes reference results into a queue; a
// monitor pops and compares on every delivery.
module tb_bin_onehot_pipe;
  localparam int BW = 4;
  localparam int OW = 12;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic [OW-1:0] oh;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cmp_count  = 0;
  int   fail_count = 0;
  exp_t exp_q[$];
  logic [15:0] model_err = 16'd0;
  logic rand_done = 1'b0;

  bin_onehot_pipe_if #(.BIN_WIDTH(BW), .ONEHOT_WIDTH(OW)) bus ();

  bin_onehot_pipe #(.BIN_WIDTH(BW), .ONEHOT_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model written from the conversion rules.
  function automatic exp_t model(input logic [1:0] mode, input logic [BW-1:0] b,
                                 input logic [OW-1:0] oh);
    exp_t e;
    int bi;
    int idx;
    logic [OW-1:0] ones;
    logic [OW-1:0] one;
    ones = '1;
    one  = 1;
    bi   = int'(b);
    e.bin = '0;
    e.oh  = '0;
    e.err = 1'b0;
    case (mode)
      2'b00: begin
        e.bin = b;
        if (bi < OW) e.oh = one << bi;
        else e.err = 1'b1;
      end
      2'b01: begin
        e.oh = oh;
        e.err = ($countones(oh) != 1);
        idx = 0;
        while (idx < OW && !oh[idx]) idx++;
        e.bin = (idx == OW) ? '0 : BW'(idx);
      end
      2'b10: begin
        e.bin = b;
        if (bi >= OW) begin
          e.oh  = ones;
          e.err = 1'b1;
        end else begin
          e.oh = ~(ones << (bi + 1));
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one transaction (from a negedge) and wait, bounded, for acceptance.
  task automatic send(input logic [1:0] mode, input logic [BW-1:0] b, input logic [OW-1:0] oh);
    int guard;
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_bin    = b;
    bus.in_onehot = oh;
    guard = 0;
    while (!bus.in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(model(mode, b, oh));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: err_count tracking, stall stability, in-order result compare.
  logic          stalled_prev = 1'b0;
  exp_t          prev_out;
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    #1;
    if (!rst) begin
      stalled_prev = 1'b0;
    end else begin
      got = '{bin: bus.out_bin, oh: bus.out_onehot, err: bus.out_err};
      chk("err_count", 32'(bus.err_count), 32'(model_err));
      if (stalled_prev) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_hold", 32'(got), 32'(prev_out));
      end
      if (bus.out_valid) begin
        chk("spurious_out", 32'(exp_q.size() != 0), 32'd1);
      end
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp_count++;
        if (got !== e) begin
          fail_count++;
          $display("FAIL result: got bin=%0h oh=%0h err=%0b expected bin=%0h oh=%0h err=%0b",
                   got.bin, got.oh, got.err, e.bin, e.oh, e.err);
        end
        if (e.err && model_err != 16'hFFFF) model_err = model_err + 16'd1;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      prev_out = got;
    end
  end

  initial begin
    logic [OW-1:0] roh;
    logic [1:0]    rmode;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'b00;
    bus.in_bin    = '0;
    bus.in_onehot = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_out_bin", 32'(bus.out_bin), 32'd0);
    chk("rst_out_onehot", 32'(bus.out_onehot), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

    // Decode with single-cycle latency
    bus.out_ready = 1'b1;
    send(2'b00, 4'd5, '0);
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("dec5_onehot", 32'(bus.out_onehot), 32'h020);
    drain();

    // Encode legal / zero / multi-hot
    send(2'b01, '0, 12'h400);
    send(2'b01, '0, 12'h000);
    send(2'b01, '0, 12'h410);
    drain();
    chk("enc_err_count", 32'(bus.err_count), 32'd2);

    // Thermometer and out-of-range codes
    send(2'b10, 4'd3, '0);
    send(2'b00, 4'd13, '0);
    send(2'b10, 4'd11, '0);
    send(2'b10, 4'd14, '0);
    send(2'b11, 4'd7, 12'h001);
    drain();

    // Backpressure: only two accepted while stalled
    bus.out_ready = 1'b0;
    send(2'b00, 4'd0, '0);
    send(2'b00, 4'd1, '0);
    chk("bp_ready_low", 32'(bus.in_ready), 32'd0);
    fork
      begin
        send(2'b00, 4'd2, '0);
        send(2'b00, 4'd3, '0);
      end
      begin
        repeat (3) @(negedge clk);
        chk("bp_queue_two", 32'(exp_q.size()), 32'd2);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random consumer stalls
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 400; n++) begin
          rmode = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0: roh = OW'(1) << $urandom_range(0, OW - 1);
            1: roh = '0;
            2: roh = OW'($urandom);
            default: roh = (OW'(1) << $urandom_range(0, OW - 1)) | (OW'(1) << $urandom_range(0, OW - 1));
          endcase
          send(rmode, BW'($urandom_range(0, (1 << BW) - 1)), roh);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    // Error counter saturation
    for (int n = 0; n < 65540; n++) begin
      send(2'b11, '0, '0);
    end
    drain();
    chk("err_saturated", 32'(bus.err_count), 32'h0000FFFF);

    // Reset while both registers are full
    bus.out_ready = 1'b0;
    send(2'b00, 4'd6, '0);
    send(2'b00, 4'd7, '0);
    chk("stall_full_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    model_err = 16'd0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_err_count", 32'(bus.err_count), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_stale_result", 32'(bus.out_valid), 32'd0);
    send(2'b00, 4'd2, '0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end
endmodule

// File: doc/bin_onehot_pipe.md
# bin_onehot_pipe

Parametrised, pipelined binary/one-hot converter with a valid/ready handshake and a 2-entry output skid buffer. It replaces free-running registered decoders wherever a stalling consumer sits downstream, such as lane selects and write-enable fan-out. Per transaction it decodes binary to one-hot, encodes one-hot to binary, or decodes binary to thermometer code. It flags illegal codes and keeps a saturating error counter.

## Interface
- BIN_WIDTH, 4, binary code width; legal range 1..8.
- ONEHOT_WIDTH, 16, one-hot width; legal range 2..2**BIN_WIDTH. It may be smaller than 2**BIN_WIDTH.
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept; registered.
- in_mode  in  2  00 decode, 01 encode, 10 thermometer, 11 reserved.
- in_bin  in  BIN_WIDTH  binary operand (modes 00/10).
- in_onehot  in  ONEHOT_WIDTH  one-hot operand (mode 01).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_bin  out  BIN_WIDTH  binary result.
- out_onehot  out  ONEHOT_WIDTH  one-hot/thermometer result.
- out_err  out  1  illegal operand for this result.
- err_count  out  16  saturating count of erroneous results delivered.

## Operation
- Accept occurs when in_valid && in_ready. Deliver occurs when out_valid && out_ready.
- Mode 00 (decode):
  - out_onehot[i] = (i == in_bin); out_bin = in_bin.
  - If in_bin >= ONEHOT_WIDTH: out_err=1 and out_onehot=0.
- Mode 01 (encode):
  - out_onehot = in_onehot; out_bin = index of the lowest set bit.
  - out_err=1 if popcount != 1.
  - All-zero input gives out_bin=0. Multi-hot input gives the lowest index.
- Mode 10 (thermometer):
  - out_onehot[i] = (i <= in_bin); out_bin = in_bin.
  - If in_bin >= ONEHOT_WIDTH: out_err=1 and out_onehot is all ones.
- Mode 11: out_err=1, out_bin=0, out_onehot=0.
- Result is computed combinationally from the accepted inputs and written into the output register or the skid register.
- Storage consists of an output register (drives the out_* ports) and one skid register.
  - On accept, the result goes to the output register if it is empty or being delivered this cycle and skid is empty. Otherwise it goes to skid.
  - On deliver with skid full, skid moves to the output register. The output register is never left empty while skid holds data.
  - in_ready(next) = skid empty after this edge.
- Ordering is strictly FIFO; no result is ever dropped or duplicated.
- err_count increments by 1 on each deliver with out_err=1 and saturates at 16'hFFFF.
- Outputs hold stable while out_valid && !out_ready.

## Timing
- Reset values (rst low at a rising edge): out_valid=0, out_bin=0, out_onehot=0, out_err=0, err_count=0, in_ready=0, skid empty.
- in_ready goes to 1 at the first rising edge with rst=1.
- Latency: accept at edge N gives out_valid=1 after edge N (visible in cycle N+1) when storage is empty.
- Throughput: 1 transaction/cycle while out_ready stays high.
- Stall behaviour:
  - out_ready low with the output register full, plus one more accept, fills skid. in_ready drops after that edge.
  - At most 2 results are held.
- Simultaneous accept and deliver:
  - Output full, skid empty: the new result replaces the output register.
  - Output full, skid full: cannot occur, since in_ready=0.
- Reset mid-operation discards both registers and clears err_count, regardless of handshake state.
- in_* inputs are ignored when in_ready=0. out_ready is ignored when out_valid=0.

## Test plan
- Reset then decode: rst low 2 cycles, release; send mode 00, in_bin=5, out_ready=1 -> one cycle later out_valid=1, out_onehot=16'h0020, out_bin=5, out_err=0.
- Encode legal and illegal: send in_onehot=16'h0400, then 16'h0000, then 16'h0410 -> out_bin 10/0/4 with out_err 0/1/1; err_count=2 after all three are delivered.
- Thermometer and range, with ONEHOT_WIDTH=12, BIN_WIDTH=4: mode 10, in_bin=3 -> out_onehot=12'h00F. Mode 00, in_bin=13 -> out_onehot=0, out_err=1.
- Backpressure: stream 4 decodes (in_bin 0..3) back-to-back with out_ready=0 -> in_ready drops after the 2nd accept and only 2 are accepted. Raise out_ready -> onehots 1, 2 delivered in order, then 4, 8 accepted and delivered. No loss or duplication.
- Saturation: preload via 65 540 mode-11 transactions -> err_count stops at 16'hFFFF.
- Reset mid-stall: fill both registers, assert rst low for one edge -> out_valid=0, err_count=0, in_ready=0. in_ready=1 the edge after release; no stale result appears.
